// File: rtl/store_pkg.sv
// Shared definitions for the store path: func3 codes, base byte masks and FSM encoding.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [3:0] MASK_SB = 4'b0001;
  localparam logic [3:0] MASK_SH = 4'b0011;
  localparam logic [3:0] MASK_SW = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2
  } state_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment: turns func3/offset/rs2 into a two-word byte mask and data image.
module store_lane_align
  import store_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  output logic [7:0]  mask8,
  output logic [63:0] data64,
  output logic        split,
  output logic        func3_valid
);

  logic [3:0]  base;
  logic [31:0] rep;

  // Narrow stores replicate their quantity so unused lanes carry copies rather than stale bits.
  always_comb begin
    base        = 4'b0000;
    rep         = 32'h0;
    func3_valid = 1'b0;
    case (func3)
      F3_SB: begin
        base        = MASK_SB;
        rep         = {4{store_data[7:0]}};
        func3_valid = 1'b1;
      end
      F3_SH: begin
        base        = MASK_SH;
        rep         = {2{store_data[15:0]}};
        func3_valid = 1'b1;
      end
      F3_SW: begin
        base        = MASK_SW;
        rep         = store_data;
        func3_valid = 1'b1;
      end
      default: ;
    endcase
    mask8  = {4'b0000, base} << off;
    data64 = {32'h0, rep} << {off, 3'b000};
    split  = |mask8[7:4];
  end

endmodule

// File: rtl/data_store_controller.sv
// Store-side MEM controller: issues word-aligned cache write beats with byte enables.
// Define MISALIGN_SPLIT_EN to split word-crossing stores into two beats instead of rejecting them.
module data_store_controller
  import store_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  store_req,
  input  logic [2:0]            func3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  misaligned_err,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_byte_en,
  input  logic                  mem_busy
);

  localparam int WW = ADDR_WIDTH - 2;

  state_t          state, state_next;
  logic [WW-1:0]   word_q;
  logic [3:0]      mask_lo_q;
  logic [31:0]     data_lo_q;
  logic [7:0]      lane_mask8;
  logic [63:0]     lane_data64;
  logic            lane_split, lane_valid;
  logic            reject, accept, done_next, err_next, done_q, err_q;

`ifdef MISALIGN_SPLIT_EN
  logic [3:0]      mask_hi_q;
  logic [31:0]     data_hi_q;
  logic            split_q;
  logic [WW-1:0]   word_inc;

  assign reject   = 1'b0;
  assign word_inc = word_q + 1'b1;
`else
  logic            unused_hi;

  assign reject    = lane_split;
  assign unused_hi = ^{lane_mask8[7:4], lane_data64[63:32]};
`endif

  store_lane_align u_align (
    .func3       (func3),
    .off         (addr[1:0]),
    .store_data  (store_data),
    .mask8       (lane_mask8),
    .data64      (lane_data64),
    .split       (lane_split),
    .func3_valid (lane_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      word_q    <= '0;
      mask_lo_q <= 4'b0000;
      data_lo_q <= 32'h0;
`ifdef MISALIGN_SPLIT_EN
      mask_hi_q <= 4'b0000;
      data_hi_q <= 32'h0;
      split_q   <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      done_q <= done_next;
      err_q  <= err_next;
      if (accept) begin
        word_q    <= addr[ADDR_WIDTH-1:2];
        mask_lo_q <= lane_mask8[3:0];
        data_lo_q <= lane_data64[31:0];
`ifdef MISALIGN_SPLIT_EN
        mask_hi_q <= lane_mask8[7:4];
        data_hi_q <= lane_data64[63:32];
        split_q   <= lane_split;
`endif
      end
    end
  end

  // Bus outputs come straight from the latched beat so they stay frozen while the cache stalls.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 32'h0;
    mem_byte_en = 4'b0000;
    case (state)
      IDLE: begin
        if (store_req) begin
          if (!lane_valid || reject) begin
            err_next = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = W0;
          end
        end
      end
      W0: begin
        mem_write   = 1'b1;
        mem_addr    = {word_q, 2'b00};
        mem_byte_en = mask_lo_q;
        mem_wdata   = data_lo_q;
        if (!mem_busy) begin
`ifdef MISALIGN_SPLIT_EN
          if (split_q) begin
            state_next = W1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
`else
          state_next = IDLE;
          done_next  = 1'b1;
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      W1: begin
        mem_write   = 1'b1;
        mem_addr    = {word_inc, 2'b00};
        mem_byte_en = mask_hi_q;
        mem_wdata   = data_hi_q;
        if (!mem_busy) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign busy           = (state != IDLE);
  assign done           = done_q;
  assign misaligned_err = err_q;

endmodule

// File: tb/tb_data_store_controller.sv
// Scoreboard bench for data_store_controller; expectations follow MISALIGN_SPLIT_EN when defined.
module tb_data_store_controller;
  import store_pkg::*;

  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        store_req;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy, done, misaligned_err, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_busy;

  beat_t beat_q[$];
  int    event_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  data_store_controller #(.ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .store_req      (store_req),
    .func3          (func3),
    .addr           (addr),
    .store_data     (store_data),
    .busy           (busy),
    .done           (done),
    .misaligned_err (misaligned_err),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_byte_en    (mem_byte_en),
    .mem_busy       (mem_busy)
  );

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.addr  = a;
    b.be    = be;
    b.wdata = wd;
    beat_q.push_back(b);
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    func3      = f3;
    addr       = a;
    store_data = d;
    store_req  = 1'b1;
    @(posedge clk);
    #1;
    store_req  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((beat_q.size() != 0 || event_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drained"}, beat_q.size() + event_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every accepted beat and every done/err pulse is matched against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_write && !mem_busy) begin
        if (beat_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_beat: addr 0x%08h be %b", mem_addr, mem_byte_en);
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          checkOutput("beat_addr", mem_addr, e.addr);
          checkOutput("beat_be", {28'h0, mem_byte_en}, {28'h0, e.be});
          checkOutput("beat_wdata", mem_wdata & lane_mask(e.be), e.wdata);
        end
      end
      if (done && misaligned_err) begin
        total++;
        bad++;
        $display("[TB] FAIL done_and_err: both high, required exclusive");
      end else if (done || misaligned_err) begin
        if (event_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_event: done=%0b err=%0b", done, misaligned_err);
        end else begin
          int ev;
          ev = event_q.pop_front();
          checkOutput("event_kind", done ? EV_DONE : EV_ERR, ev);
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    store_req  = 1'b0;
    func3      = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    mem_busy   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'h0, busy}, 0);
    checkOutput("rst_done", {31'h0, done}, 0);
    checkOutput("rst_err", {31'h0, misaligned_err}, 0);
    checkOutput("rst_write", {31'h0, mem_write}, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_be", {28'h0, mem_byte_en}, 0);
    reset = 1'b0;

    push_beat(32'h1000, 4'b1000, 32'hAB00_0000);
    event_q.push_back(EV_DONE);
    applyStimulus(F3_SB, 32'h1003, 32'h0000_00AB);
    drain("sb_off3");

    push_beat(32'h2000, 4'b0110, 32'h00BE_EF00);
    event_q.push_back(EV_DONE);
    applyStimulus(F3_SH, 32'h2001, 32'h0000_BEEF);
    drain("sh_off1");

    push_beat(32'h6000, 4'b0100, 32'h005A_0000);
    event_q.push_back(EV_DONE);
    applyStimulus(F3_SB, 32'h6002, 32'hFFFF_FF5A);
    drain("sb_off2");

`ifdef MISALIGN_SPLIT_EN
    push_beat(32'h3000, 4'b1100, 32'h3344_0000);
    push_beat(32'h3004, 4'b0011, 32'h0000_1122);
    event_q.push_back(EV_DONE);
`else
    event_q.push_back(EV_ERR);
`endif
    applyStimulus(F3_SW, 32'h3002, 32'h1122_3344);
    drain("sw_off2");
    checkOutput("sw_off2_idle", {31'h0, busy}, 0);

`ifdef MISALIGN_SPLIT_EN
    push_beat(32'h5000, 4'b1000, 32'h3400_0000);
    push_beat(32'h5004, 4'b0001, 32'h0000_0012);
    event_q.push_back(EV_DONE);
`else
    event_q.push_back(EV_ERR);
`endif
    applyStimulus(F3_SH, 32'h5003, 32'h0000_1234);
    drain("sh_off3");

`ifdef MISALIGN_SPLIT_EN
    push_beat(32'hFFFF_FFFC, 4'b1100, 32'hC3D4_0000);
    push_beat(32'h0000_0000, 4'b0011, 32'h0000_A1B2);
    event_q.push_back(EV_DONE);
`else
    event_q.push_back(EV_ERR);
`endif
    applyStimulus(F3_SW, 32'hFFFF_FFFE, 32'hA1B2_C3D4);
    drain("sw_wrap");

    // Stalled aligned word: bus frozen for four cycles, a second request in the middle is dropped.
    mem_busy = 1'b1;
    push_beat(32'h4000, 4'b1111, 32'hCAFE_F00D);
    event_q.push_back(EV_DONE);
    applyStimulus(F3_SW, 32'h4000, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("hold_write", {31'h0, mem_write}, 1);
      checkOutput("hold_addr", mem_addr, 32'h4000);
      checkOutput("hold_be", {28'h0, mem_byte_en}, 32'hF);
      checkOutput("hold_wdata", mem_wdata, 32'hCAFE_F00D);
      if (i == 0) begin
        func3      = F3_SB;
        addr       = 32'h7000;
        store_data = 32'h77;
        store_req  = 1'b1;
      end
      @(posedge clk);
      #1;
      store_req = 1'b0;
      if (i == 2) mem_busy = 1'b0;
    end
    @(negedge clk);
    checkOutput("hold_done", {31'h0, done}, 1);
    drain("sw_stall");

    // Reset in the middle of a store: no done, bus goes quiet on the next edge.
`ifdef MISALIGN_SPLIT_EN
    push_beat(32'h3000, 4'b1100, 32'h3344_0000);
    applyStimulus(F3_SW, 32'h3002, 32'h1122_3344);
    @(posedge clk);
    #1;
    mem_busy = 1'b1;
`else
    mem_busy = 1'b1;
    applyStimulus(F3_SW, 32'h8000, 32'h1122_3344);
`endif
    @(negedge clk);
    checkOutput("pre_rst_busy", {31'h0, busy}, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_busy = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_write", {31'h0, mem_write}, 0);
    checkOutput("mid_rst_busy", {31'h0, busy}, 0);
    checkOutput("mid_rst_done", {31'h0, done}, 0);

    event_q.push_back(EV_ERR);
    applyStimulus(3'b011, 32'h9000, 32'hDEAD_BEEF);
    drain("f3_011");

    event_q.push_back(EV_ERR);
    applyStimulus(3'b111, 32'h9004, 32'h1234_5678);
    drain("f3_111");
    checkOutput("final_busy", {31'h0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_store_controller.md
Name: data_store_controller

Overview:
- Store-side counterpart of the load data extractor. It sits between the MEM stage and the data cache write port.
- Takes a store request (func3, byte address, rs2 data) and converts it into word-aligned cache write beats with per-byte enables.
- Misaligned stores that cross a word boundary are split into two sequential beats.
- Handshakes with the cache via a busy/stall signal and reports completion or error to the pipeline.

Parameters:
- ADDR_WIDTH, 32, width of byte address and mem_addr.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- store_req  in  1  one-cycle request pulse; sampled only in IDLE
- func3  in  3  store width: 000 sb, 001 sh, 010 sw
- addr  in  ADDR_WIDTH  byte address of store
- store_data  in  32  rs2 value; LSBs hold the stored quantity
- busy  out  1  high whenever state != IDLE (pipeline stall)
- done  out  1  one-cycle pulse after final beat accepted
- misaligned_err  out  1  one-cycle pulse: store rejected, no write issued
- mem_write  out  1  write beat valid
- mem_addr  out  ADDR_WIDTH  word-aligned address, [1:0]=00
- mem_wdata  out  32  lane-aligned write data
- mem_byte_en  out  4  byte-lane enables, bit i -> mem_wdata[8i+7:8i]
- mem_busy  in  1  cache stall; beat accepted on an edge with mem_write=1 and mem_busy=0

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values: state IDLE; busy, done, misaligned_err, mem_write = 0; mem_addr, mem_wdata, mem_byte_en = 0.
- Reset mid-operation: returns to IDLE on the next edge, with no done. A beat0 already accepted is not rolled back.
- Acceptance: in IDLE with store_req=1, latch func3, addr, store_data and compute lanes.
  - off = addr[1:0].
  - base mask: 0001 (sb), 0011 (sh), 1111 (sw).
  - mask8 = {4'b0, base} << off.
  - data64 = {32'b0, store_data} << (8*off).
  - split = |mask8[7:4].
- sb/sh data outside the base mask is don't-care on the bus; implementation drives replicated bytes.
- Invalid func3 (any except 000/001/010): misaligned_err pulses the next cycle, no write, stays IDLE.
- States:
  - IDLE -> W0 on valid acceptance.
  - W0: mem_write=1, mem_addr={addr[AW-1:2],2'b00}, mem_byte_en=mask8[3:0], mem_wdata=data64[31:0]. Held stable while mem_busy=1. On acceptance: -> W1 if split, else -> IDLE with done.
  - W1: mem_addr=W0 addr+4, mem_byte_en=mask8[7:4], mem_wdata=data64[63:32]. On acceptance -> IDLE with done.
- Latency: aligned store, mem_busy=0 → req at cycle 0, beat at cycle 1, done at cycle 2. Split store → done at cycle 3. Each mem_busy cycle adds one cycle.
- store_req while busy=1: ignored; the pipeline must be stalled by busy.
- Address wrap: addr+4 wraps modulo 2^ADDR_WIDTH.
- done and misaligned_err are never high in the same cycle.

Optional Feature:
- MISALIGN_SPLIT_EN
- Defined: word-crossing stores are split into W0/W1 as above.
- Undefined: any store with split=1 pulses misaligned_err the cycle after request, issues no beat, and the W1 state is removed. In-word misaligned sh (off=1) is still performed in a single beat.

Decomposition:
- Shared package (store_pkg):
  - func3 constants F3_SB, F3_SH, F3_SW.
  - state encoding IDLE/W0/W1.
  - base-mask constants.
- One combinational sub-module, store_lane_align: inputs func3, off, store_data; outputs mask8, data64, split, func3_valid. It is reused by the FSM.

Test Plan:
- sb addr=0x1003 data=0xAB, mem_busy=0 → cycle1: mem_addr=0x1000, be=1000, wdata[31:24]=0xAB; done at cycle2.
- sh addr=0x2001 data=0xBEEF → single beat, be=0110, wdata[23:8]=0xBEEF, no split.
- sw addr=0x3002 data=0x11223344, MISALIGN_SPLIT_EN defined → beat0 0x3000 be=1100 wdata[31:16]=0x3344; beat1 0x3004 be=0011 wdata[15:0]=0x1122; done cycle3.
- Same sw without macro → misaligned_err pulse cycle1, mem_write never high, busy 0 afterward.
- sw aligned with mem_busy=1 for 3 cycles → mem_write/addr/wdata/be held constant 4 cycles, done one cycle after release; second store_req during busy ignored.
- Reset asserted in W1 → next cycle IDLE, mem_write=0, no done; func3=011 request → misaligned_err pulse, no write.
